// File: rtl/stream_demux_n.sv
// Registered 1:N stream demux with one-entry slot per channel; beat visible on out_valid one cycle after acceptance.
// Backpressure: in_ready reflects only the selected channel's slot (out_ready -> in_ready comb path); STREAM_DEMUX_SELERR_EN enables sel_err.
module stream_demux_n #(
  parameter int N  = 4,
  parameter int DW = 8,
  localparam int SW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [SW-1:0]   in_sel,
  input  logic [DW-1:0]   in_data,
  output logic [N-1:0]    out_valid,
  input  logic [N-1:0]    out_ready,
  output logic [N*DW-1:0] out_data,
  output logic            sel_err
);

  localparam logic [SW:0] NUM_CH = (SW+1)'(N);

  logic [N-1:0]         v;
  logic [N-1:0][DW-1:0] d;
  logic [N-1:0]         sel_hit;
  logic [N-1:0]         load;
  logic                 in_range;
  logic                 accept;

  always_comb begin
    sel_hit = '0;
    for (int k = 0; k < N; k++) begin
      sel_hit[k] = (in_sel == SW'(k));
    end
  end

  // Out-of-range selects are always accepted so a bad beat can never wedge the producer.
  always_comb begin
    in_range = ({1'b0, in_sel} < NUM_CH);
    in_ready = in_range ? |(sel_hit & (~v | out_ready)) : 1'b1;
    accept   = in_valid & in_ready;
    load     = sel_hit & {N{accept}};
  end

  // A load wins over a drain on the same channel, giving one beat per cycle per channel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v <= '0;
      d <= '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (load[k]) begin
          v[k] <= 1'b1;
          d[k] <= in_data;
        end else if (out_ready[k]) begin
          v[k] <= 1'b0;
        end
      end
    end
  end

  assign out_valid = v;
  assign out_data  = d;

`ifdef STREAM_DEMUX_SELERR_EN
  logic sel_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_err_q <= 1'b0;
    end else begin
      sel_err_q <= accept & ~in_range;
    end
  end

  assign sel_err = sel_err_q;
`else
  assign sel_err = 1'b0;
`endif

endmodule

// File: tb/tb_stream_demux_n.sv
// Bench for stream_demux_n: directed vector table, async-reset and bad-select sequences, randomized scoreboard run.
module tb_stream_demux_n;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_sel;
  logic [7:0]  in_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [31:0] out_data;
  logic        sel_err;

  logic        in_valid3;
  logic        in_ready3;
  logic [1:0]  in_sel3;
  logic [7:0]  in_data3;
  logic [2:0]  out_valid3;
  logic [2:0]  out_ready3;
  logic [23:0] out_data3;
  logic        sel_err3;

  int nvec  = 0;
  int nfail = 0;

  stream_demux_n #(.N(4), .DW(8)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .sel_err(sel_err)
  );

  stream_demux_n #(.N(3), .DW(8)) u_dut3 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid3), .in_ready(in_ready3), .in_sel(in_sel3), .in_data(in_data3),
    .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3),
    .sel_err(sel_err3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        vld;
    logic [1:0]  sel;
    logic [7:0]  dat;
    logic [3:0]  ordy;
    logic        e_rdy;
    logic [3:0]  e_ov;
    logic [31:0] e_od;
  } vec_t;

  vec_t tbl [22];

  // Behavioural model for the random run: per-channel list of beats accepted but not yet delivered.
  logic [7:0] mq [4][$];

`ifdef STREAM_DEMUX_SELERR_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  initial begin
    logic [3:0] exp_ov;
    logic       exp_rdy;
    int         accepted;
    int         delivered;
    int         cyc;

    // Stimulus table: inputs held for one cycle; expectations sampled before the following edge.
    tbl[0]  = '{1'b1, 2'd0, 8'h11, 4'hF, 1'b1, 4'b0000, 32'h00000000};
    tbl[1]  = '{1'b1, 2'd1, 8'h22, 4'hF, 1'b1, 4'b0001, 32'h00000011};
    tbl[2]  = '{1'b1, 2'd2, 8'h33, 4'hF, 1'b1, 4'b0010, 32'h00002211};
    tbl[3]  = '{1'b1, 2'd3, 8'h44, 4'hF, 1'b1, 4'b0100, 32'h00332211};
    tbl[4]  = '{1'b0, 2'd0, 8'h00, 4'hF, 1'b1, 4'b1000, 32'h44332211};
    tbl[5]  = '{1'b0, 2'd0, 8'h00, 4'hF, 1'b1, 4'b0000, 32'h44332211};
    tbl[6]  = '{1'b1, 2'd2, 8'hA0, 4'hB, 1'b1, 4'b0000, 32'h44332211};
    tbl[7]  = '{1'b1, 2'd2, 8'hA1, 4'hB, 1'b0, 4'b0100, 32'h44A02211};
    tbl[8]  = '{1'b0, 2'd2, 8'hA1, 4'hB, 1'b0, 4'b0100, 32'h44A02211};
    tbl[9]  = '{1'b1, 2'd2, 8'hA1, 4'hF, 1'b1, 4'b0100, 32'h44A02211};
    tbl[10] = '{1'b1, 2'd1, 8'hB0, 4'hF, 1'b1, 4'b0100, 32'h44A12211};
    tbl[11] = '{1'b0, 2'd0, 8'h00, 4'hF, 1'b1, 4'b0010, 32'h44A1B011};
    tbl[12] = '{1'b0, 2'd0, 8'h00, 4'hF, 1'b1, 4'b0000, 32'h44A1B011};
    tbl[13] = '{1'b1, 2'd3, 8'h5A, 4'hF, 1'b1, 4'b0000, 32'h44A1B011};
    tbl[14] = '{1'b1, 2'd3, 8'h5B, 4'hF, 1'b1, 4'b1000, 32'h5AA1B011};
    tbl[15] = '{1'b0, 2'd0, 8'h00, 4'hF, 1'b1, 4'b1000, 32'h5BA1B011};
    tbl[16] = '{1'b0, 2'd0, 8'h00, 4'hF, 1'b1, 4'b0000, 32'h5BA1B011};
    tbl[17] = '{1'b1, 2'd3, 8'hC3, 4'h7, 1'b1, 4'b0000, 32'h5BA1B011};
    tbl[18] = '{1'b1, 2'd0, 8'hD0, 4'h7, 1'b1, 4'b1000, 32'hC3A1B011};
    tbl[19] = '{1'b1, 2'd3, 8'hC4, 4'h7, 1'b0, 4'b1001, 32'hC3A1B0D0};
    tbl[20] = '{1'b0, 2'd3, 8'h00, 4'hF, 1'b1, 4'b1000, 32'hC3A1B0D0};
    tbl[21] = '{1'b0, 2'd0, 8'h00, 4'hF, 1'b1, 4'b0000, 32'hC3A1B0D0};

    rst = 1'b1;
    in_valid = 1'b0; in_sel = 2'd0; in_data = 8'h00; out_ready = 4'h0;
    in_valid3 = 1'b0; in_sel3 = 2'd0; in_data3 = 8'h00; out_ready3 = 3'h0;
    #2;
    check("reset_out_valid", 64'(out_valid), 64'h0);
    check("reset_out_data", 64'(out_data), 64'h0);
    check("reset_sel_err", 64'(sel_err), 64'h0);
    check("reset_sel_err_n3", 64'(sel_err3), 64'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      in_valid = tbl[i].vld; in_sel = tbl[i].sel; in_data = tbl[i].dat; out_ready = tbl[i].ordy;
      #1;
      check($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'(tbl[i].e_rdy));
      check($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(tbl[i].e_ov));
      check($sformatf("vec%0d_out_data", i), 64'(out_data), 64'(tbl[i].e_od));
    end

    // Asynchronous reset while ch0 and ch1 hold beats.
    @(negedge clk);
    in_valid = 1'b1; in_sel = 2'd0; in_data = 8'hE0; out_ready = 4'h0;
    @(negedge clk);
    in_sel = 2'd1; in_data = 8'hE1;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("arst_pre_out_valid", 64'(out_valid), 64'h3);
    #2;
    rst = 1'b1;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'h0);
    check("arst_out_data", 64'(out_data), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b1; in_sel = 2'd1; in_data = 8'hF1; out_ready = 4'hF;
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'h1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("post_rst_out_valid", 64'(out_valid), 64'h2);
    check("post_rst_out_data", 64'(out_data), 64'h0000F100);
    @(negedge clk);
    #1;
    check("post_rst_drained", 64'(out_valid), 64'h0);

    // N=3: out-of-range select is consumed and dropped.
    @(negedge clk);
    in_valid3 = 1'b1; in_sel3 = 2'd3; in_data3 = 8'hFF; out_ready3 = 3'h7;
    #1;
    check("n3_bad_in_ready", 64'(in_ready3), 64'h1);
    @(negedge clk);
    in_valid3 = 1'b0;
    #1;
    check("n3_bad_no_valid", 64'(out_valid3), 64'h0);
    check("n3_sel_err_pulse", 64'(sel_err3), 64'(EXP_ERR));
    @(negedge clk);
    #1;
    check("n3_sel_err_one_cycle", 64'(sel_err3), 64'h0);
    check("n3_still_no_valid", 64'(out_valid3), 64'h0);
    in_valid3 = 1'b1; in_sel3 = 2'd3; in_data3 = 8'hFE;
    @(negedge clk);
    in_data3 = 8'hFD;
    #1;
    check("n3_b2b_err_1", 64'(sel_err3), 64'(EXP_ERR));
    @(negedge clk);
    in_sel3 = 2'd2; in_data3 = 8'h77; out_ready3 = 3'h0;
    #1;
    check("n3_b2b_err_2", 64'(sel_err3), 64'(EXP_ERR));
    check("n3_good_in_ready", 64'(in_ready3), 64'h1);
    @(negedge clk);
    in_valid3 = 1'b0;
    #1;
    check("n3_good_err_low", 64'(sel_err3), 64'h0);
    check("n3_good_valid", 64'(out_valid3), 64'h4);
    check("n3_good_data", 64'(out_data3[23:16]), 64'h77);
    check("n3_no_slot_corrupt", 64'(out_data3[15:0]), 64'h0);

    // Randomized run scoreboarded per channel.
    accepted = 0;
    delivered = 0;
    cyc = 0;
    while (accepted < 10000 && cyc < 40000) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_sel    = 2'($urandom_range(0, 3));
      in_data   = 8'($urandom);
      out_ready = 4'($urandom);
      #1;
      exp_ov = '0;
      for (int k = 0; k < 4; k++) exp_ov[k] = (mq[k].size() != 0);
      exp_rdy = (mq[in_sel].size() == 0) || out_ready[in_sel];
      check("rnd_in_ready", 64'(in_ready), 64'(exp_rdy));
      check("rnd_out_valid", 64'(out_valid), 64'(exp_ov));
      for (int k = 0; k < 4; k++) begin
        if (mq[k].size() != 0) begin
          check($sformatf("rnd_ch%0d_data", k), 64'(out_data[k*8 +: 8]), 64'(mq[k][0]));
          if (out_ready[k]) begin
            void'(mq[k].pop_front());
            delivered++;
          end
        end
      end
      if (in_valid && exp_rdy) begin
        mq[in_sel].push_back(in_data);
        accepted++;
      end
      check("rnd_sel_err_zero", 64'(sel_err), 64'h0);
      cyc++;
    end
    check("rnd_beat_budget", 64'(accepted >= 10000), 64'h1);

    @(negedge clk);
    in_valid = 1'b0; out_ready = 4'hF;
    for (int k = 0; k < 4; k++) begin
      delivered += mq[k].size();
      mq[k].delete();
    end
    @(negedge clk);
    #1;
    check("rnd_final_empty", 64'(out_valid), 64'h0);
    check("rnd_no_loss", 64'(delivered), 64'(accepted));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
